// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin arbiter for the shared DDR2 command/data port.
// The I-cache (req0) and D-cache (req1) compete for the port. The winning
// command is latched into registered mem_* outputs and held until mem_ready.
// Ready and read data are routed back to the winner only.
// Optional feature macro: ARB_TIMEOUT_EN (BUSY watchdog and sticky timeout_err).
module ddr_port_arbiter #(
    parameter int ADDR_W         = 28,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_id,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state, state_nxt;
    logic   last_grant;   // requester granted most recently; loses the next tie
    logic   winner;
    logic   any_valid;
    logic   done;         // normal completion this cycle
    logic   tmo;          // watchdog expiry this cycle (never with mem_ready)
    logic   finish;

    assign any_valid = req0_valid | req1_valid;
    assign done      = (state == BUSY) & mem_ready;
    assign finish    = done | tmo;

`ifdef ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo = (state == BUSY) & ~mem_ready & (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog: count BUSY cycles without mem_ready, flag expiry stickily
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE)
                tmo_cnt <= '0;
            else if (!mem_ready)
                tmo_cnt <= tmo_cnt + 32'd1;
            if (tmo)
                timeout_err <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and winner selection
    always_comb begin
        state_nxt = state;
        winner    = 1'b0;
        if (req0_valid && req1_valid)
            winner = ~last_grant;
        else
            winner = req1_valid;
        case (state)
            IDLE:    if (any_valid) state_nxt = BUSY;
            BUSY:    if (finish)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, command latch and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_valid  <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_valid) begin
                mem_valid <= 1'b1;
                busy      <= 1'b1;
                grant_id  <= winner;
                mem_rw    <= winner ? req1_rw    : req0_rw;
                mem_addr  <= winner ? req1_addr  : req0_addr;
                mem_wdata <= winner ? req1_wdata : req0_wdata;
            end else if (finish) begin
                mem_valid  <= 1'b0;
                busy       <= 1'b0;
                last_grant <= grant_id;
            end
        end
    end

    // Completion routing; a reset cycle abandons the transaction silently
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        req0_rdata = '0;
        req1_rdata = '0;
        if (finish && !rst) begin
            if (grant_id) begin
                req1_ready = 1'b1;
                req1_rdata = done ? mem_rdata : '0;
            end else begin
                req0_ready = 1'b1;
                req0_rdata = done ? mem_rdata : '0;
            end
        end
    end

endmodule
